// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants and helpers for the per-channel TMDS encoder:
//   - period select codes (mode input of tmds_channel_encoder)
//   - the four control tokens and the two guard-band symbols
//   - the 16-entry TERC4 symbol table used for data islands
//   - popcount8, a small bit-count helper used by both pipeline stages
// Symbol constants are written as dout[9:0]; bit 0 is transmitted first.
// -----------------------------------------------------------------------------
package tmds_pkg;

  // Period select codes; 5..7 are reserved and behave as CTRL.
  localparam logic [2:0] MODE_CTRL        = 3'd0;
  localparam logic [2:0] MODE_VIDEO       = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD = 3'd2;
  localparam logic [2:0] MODE_DATA_ISLAND = 3'd3;
  localparam logic [2:0] MODE_DATA_GUARD  = 3'd4;

  // Control tokens indexed by {c1,c0}.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Guard-band symbols: GUARD_A is the video guard on channels 0/2,
  // GUARD_B is the video guard on channel 1 and the data guard on 1/2.
  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] sel);
    logic [9:0] sym;
    case (sel)
      2'b00:   sym = CTRL_TOKEN_00;
      2'b01:   sym = CTRL_TOKEN_01;
      2'b10:   sym = CTRL_TOKEN_10;
      default: sym = CTRL_TOKEN_11;
    endcase
    return sym;
  endfunction

  function automatic logic [9:0] terc4_lookup(input logic [3:0] nib);
    logic [9:0] sym;
    case (nib)
      4'h0:    sym = 10'b1010011100;
      4'h1:    sym = 10'b1001100011;
      4'h2:    sym = 10'b1011100100;
      4'h3:    sym = 10'b1011100010;
      4'h4:    sym = 10'b0101110001;
      4'h5:    sym = 10'b0100011110;
      4'h6:    sym = 10'b0110001110;
      4'h7:    sym = 10'b0100111100;
      4'h8:    sym = 10'b1011001100;
      4'h9:    sym = 10'b0100111001;
      4'hA:    sym = 10'b0110011100;
      4'hB:    sym = 10'b1011000110;
      4'hC:    sym = 10'b1010001110;
      4'hD:    sym = 10'b1001110001;
      4'hE:    sym = 10'b0101100011;
      default: sym = 10'b1011000011;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// -----------------------------------------------------------------------------
// tmds_qm_stage
// First pipeline stage of the TMDS encoder: transition-minimised q_m word
// (XOR or XNOR chain chosen by the pixel's ones count) registered together
// with the period select and the side-band inputs needed by stage 2.
// Ports:
//   clk, rst       pixel clock, synchronous active-high reset
//   ce             clock enable; registers hold while low
//   mode/din/ctrl/terc4   raw inputs from the timing generator
//   q_m_reg        registered 9-bit q_m (bit 8 = 1 for XOR, 0 for XNOR)
//   mode_reg, ctrl_reg, terc4_reg   side-band inputs aligned with q_m_reg
//   valid_reg      high once this stage has captured a post-reset input
// -----------------------------------------------------------------------------
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [2:0] mode,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  input  logic [3:0] terc4,
  output logic [8:0] q_m_reg,
  output logic [2:0] mode_reg,
  output logic [1:0] ctrl_reg,
  output logic [3:0] terc4_reg,
  output logic       valid_reg
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] q_m_next;

  assign n1 = popcount8(din);
  // XNOR chain for ones-heavy pixels (ties broken on din[0]) keeps the
  // number of transitions in the 8 data bits low.
  assign use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);

  always_comb begin
    q_m_next    = '0;
    q_m_next[0] = din[0];
    for (int i = 1; i < 8; i++) begin
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ din[i]) : (q_m_next[i-1] ^ din[i]);
    end
    q_m_next[8] = ~use_xnor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_m_reg   <= '0;
      mode_reg  <= MODE_CTRL;
      ctrl_reg  <= 2'b00;
      terc4_reg <= '0;
      valid_reg <= 1'b0;
    end else if (ce) begin
      q_m_reg   <= q_m_next;
      mode_reg  <= mode;
      ctrl_reg  <= ctrl;
      terc4_reg <= terc4;
      valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
// One TMDS/HDMI channel encoder with a 2-stage pipeline: stage 1 produces
// q_m (tmds_qm_stage), stage 2 applies DC balancing for video or selects a
// fixed symbol for control, guard-band and TERC4 data-island periods.
// Parameters:
//   CHANNEL  0..2, selects guard-band symbols and channel-0 data-guard TERC4
//   DISP_W   width of the signed running-disparity counter (>= 5)
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   ce           clock enable for the whole pipeline and the disparity
//   mode         period select (see tmds_pkg MODE_*)
//   din          8-bit pixel component (VIDEO)
//   ctrl         {c1,c0} token select; {VSYNC,HSYNC} on channel 0 data guard
//   terc4        data-island nibble
//   dout         10-bit symbol, bit 0 first on the wire
//   dout_valid   stage 2 holds a symbol captured after reset
//   disparity    signed running disparity after the current dout
// -----------------------------------------------------------------------------
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int DISP_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [2:0]               mode,
  input  logic [7:0]               din,
  input  logic [1:0]               ctrl,
  input  logic [3:0]               terc4,
  output logic [9:0]               dout,
  output logic                     dout_valid,
  output logic signed [DISP_W-1:0] disparity
);

  localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);
  localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);

  logic [8:0] q_m_reg;
  logic [2:0] mode_reg;
  logic [1:0] ctrl_reg;
  logic [3:0] terc4_reg;
  logic       s1_valid_reg;

  tmds_qm_stage u_qm_stage (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .mode      (mode),
    .din       (din),
    .ctrl      (ctrl),
    .terc4     (terc4),
    .q_m_reg   (q_m_reg),
    .mode_reg  (mode_reg),
    .ctrl_reg  (ctrl_reg),
    .terc4_reg (terc4_reg),
    .valid_reg (s1_valid_reg)
  );

  // ---------------- stage 2: DC balance / period symbol select -------------
  logic [9:0]               dout_reg, dout_next;
  logic signed [DISP_W-1:0] cnt_reg, cnt_next;
  logic                     valid_reg;

  logic [3:0]               n1q;
  logic signed [DISP_W-1:0] n1q_s, diff;
  logic                     q_m8;
  logic                     cnt_pos, cnt_neg;

  assign q_m8    = q_m_reg[8];
  assign n1q     = popcount8(q_m_reg[7:0]);
  assign n1q_s   = signed'({{(DISP_W-4){1'b0}}, n1q});
  // n1q - n0q with n0q = 8 - n1q
  assign diff    = n1q_s - (EIGHT - n1q_s);
  assign cnt_pos = !cnt_reg[DISP_W-1] && (cnt_reg != '0);
  assign cnt_neg = cnt_reg[DISP_W-1];

  always_comb begin
    dout_next = ctrl_token(ctrl_reg);
    cnt_next  = '0;
    case (mode_reg)
      MODE_VIDEO: begin
        if ((cnt_reg == '0) || (n1q == 4'd4)) begin
          // No bias to correct: q_m8 alone decides inversion.
          dout_next = {~q_m8, q_m8, q_m8 ? q_m_reg[7:0] : ~q_m_reg[7:0]};
          cnt_next  = cnt_reg + (q_m8 ? diff : -diff);
        end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
          // Word would push disparity further the same way: invert it.
          dout_next = {1'b1, q_m8, ~q_m_reg[7:0]};
          cnt_next  = cnt_reg + (q_m8 ? TWO : '0) - diff;
        end else begin
          dout_next = {1'b0, q_m8, q_m_reg[7:0]};
          cnt_next  = cnt_reg - (q_m8 ? '0 : TWO) + diff;
        end
      end
      MODE_VIDEO_GUARD: dout_next = (CHANNEL == 1) ? GUARD_B : GUARD_A;
      MODE_DATA_ISLAND: dout_next = terc4_lookup(terc4_reg);
      MODE_DATA_GUARD:  dout_next = (CHANNEL == 0) ? terc4_lookup({2'b11, ctrl_reg}) : GUARD_B;
      default:          dout_next = ctrl_token(ctrl_reg);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg  <= CTRL_TOKEN_00;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (ce) begin
      dout_reg  <= dout_next;
      cnt_reg   <= cnt_next;
      valid_reg <= s1_valid_reg;
    end
  end

  assign dout       = dout_reg;
  assign disparity  = cnt_reg;
  assign dout_valid = valid_reg;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_encoder
// Self-checking bench for tmds_channel_encoder. Three instances (CHANNEL
// 0/1/2) share one stimulus; a behavioural model of channel 0 predicts each
// symbol and the running disparity, and a DVI decoder recovers video pixels.
// -----------------------------------------------------------------------------
module tb_tmds_channel_encoder;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [2:0] mode;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [3:0] terc4;

  logic [9:0]        dout0, dout1, dout2;
  logic              v0, v1, v2;
  logic signed [4:0] disp0, disp1, disp2;

  tmds_channel_encoder #(.CHANNEL(0), .DISP_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .din(din), .ctrl(ctrl),
    .terc4(terc4), .dout(dout0), .dout_valid(v0), .disparity(disp0));
  tmds_channel_encoder #(.CHANNEL(1), .DISP_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .din(din), .ctrl(ctrl),
    .terc4(terc4), .dout(dout1), .dout_valid(v1), .disparity(disp1));
  tmds_channel_encoder #(.CHANNEL(2), .DISP_W(5)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .din(din), .ctrl(ctrl),
    .terc4(terc4), .dout(dout2), .dout_valid(v2), .disparity(disp2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [9:0] sym;
    int         disp;
    bit         is_video;
    logic [7:0] d;
  } exp_t;

  exp_t       pend[$];
  exp_t       cur;
  bit         cur_valid;
  int         model_cnt;
  logic [9:0] terc4_tab [16];
  logic [9:0] ctrl_tab [4];

  localparam logic [9:0] TOK00 = 10'b1101010100;

  // Channel-0 symbol from the encoding rules; updates model_cnt.
  function automatic logic [9:0] ref_encode(input logic [2:0] m, input logic [7:0] d,
                                            input logic [1:0] c, input logic [3:0] t);
    logic [9:0] s;
    logic [7:0] q;
    int         n1, n1q, n0q;
    bit         use_xnor;
    logic       qm8;
    if (m != 3'd1) begin
      model_cnt = 0;
      case (m)
        3'd2:    s = 10'b1011001100;
        3'd3:    s = terc4_tab[t];
        3'd4:    s = terc4_tab[{2'b11, c}];
        default: s = ctrl_tab[c];
      endcase
      return s;
    end
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    qm8 = use_xnor ? 1'b0 : 1'b1;
    n1q = $countones(q);
    n0q = 8 - n1q;
    if (model_cnt == 0 || n1q == n0q) begin
      s = {~qm8, qm8, qm8 ? q : ~q};
      model_cnt += qm8 ? (n1q - n0q) : (n0q - n1q);
    end else if ((model_cnt > 0 && n1q > n0q) || (model_cnt < 0 && n0q > n1q)) begin
      s = {1'b1, qm8, ~q};
      model_cnt += 2 * int'(qm8) + n0q - n1q;
    end else begin
      s = {1'b0, qm8, q};
      model_cnt += -2 * (1 - int'(qm8)) + n1q - n0q;
    end
    return s;
  endfunction

  // Receiver-side DVI decode of a video symbol.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Drive one clock of stimulus and advance the model (2-symbol latency).
  task automatic step(input bit r, input bit c, input logic [2:0] m, input logic [7:0] d,
                      input logic [1:0] cc, input logic [3:0] t);
    exp_t e;
    rst = r; ce = c; mode = m; din = d; ctrl = cc; terc4 = t;
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      model_cnt = 0;
      cur = '{TOK00, 0, 1'b0, 8'h00};
      cur_valid = 1'b0;
    end else if (c) begin
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        cur_valid = 1'b1;
      end
      e.sym = ref_encode(m, d, cc, t);
      e.disp = model_cnt;
      e.is_video = (m == 3'd1);
      e.d = d;
      pend.push_back(e);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 3'd0, 8'h00, 2'b00, 4'h0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd1, 8'hA5, 2'b11, 4'hF);
    step(1'b1, 1'b1, 3'd1, 8'h5A, 2'b10, 4'h3);
    $display("reset: dout=%b disp=%0d valid=%b", dout0, disp0, v0);
    n_checks++; if (dout0 !== TOK00) $display("FAIL reset_dout got %b exp %b", dout0, TOK00); else n_pass++;
    n_checks++; if (disp0 !== 5'sd0) $display("FAIL reset_disp got %0d exp 0", disp0); else n_pass++;
    n_checks++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", v0); else n_pass++;
  endtask

  task automatic test_video_zero();
    do_reset();
    step(1'b0, 1'b1, 3'd1, 8'h00, 2'b00, 4'h0);
    $display("video00 #1: dout=%b disp=%0d valid=%b", dout0, disp0, v0);
    n_checks++; if (v0 !== 1'b0) $display("FAIL v0_first_valid got %b exp 0", v0); else n_pass++;
    step(1'b0, 1'b1, 3'd1, 8'h00, 2'b00, 4'h0);
    $display("video00 #2: dout=%b disp=%0d valid=%b", dout0, disp0, v0);
    n_checks++; if (v0 !== 1'b1) $display("FAIL v0_second_valid got %b exp 1", v0); else n_pass++;
    n_checks++; if (dout0 !== 10'b0100000000) $display("FAIL v0_sym1 got %b exp 0100000000", dout0); else n_pass++;
    n_checks++; if (disp0 !== -5'sd8) $display("FAIL v0_disp1 got %0d exp -8", disp0); else n_pass++;
    step(1'b0, 1'b1, 3'd0, 8'h00, 2'b00, 4'h0);
    $display("video00 #3: dout=%b disp=%0d valid=%b", dout0, disp0, v0);
    n_checks++; if (dout0 !== 10'b1111111111) $display("FAIL v0_sym2 got %b exp 1111111111", dout0); else n_pass++;
    n_checks++; if (disp0 !== 5'sd2) $display("FAIL v0_disp2 got %0d exp 2", disp0); else n_pass++;
    n_checks++; if (decode(dout0) !== 8'h00) $display("FAIL v0_decode got %h exp 00", decode(dout0)); else n_pass++;
  endtask

  task automatic test_video_ff_ctrl();
    do_reset();
    step(1'b0, 1'b1, 3'd1, 8'hFF, 2'b00, 4'h0);
    step(1'b0, 1'b1, 3'd0, 8'h00, 2'b01, 4'h0);
    $display("videoFF: dout=%b disp=%0d", dout0, disp0);
    n_checks++; if (dout0 !== 10'b1000000000) $display("FAIL ff_sym got %b exp 1000000000", dout0); else n_pass++;
    n_checks++; if (disp0 !== -5'sd8) $display("FAIL ff_disp got %0d exp -8", disp0); else n_pass++;
    step(1'b0, 1'b1, 3'd0, 8'h00, 2'b01, 4'h0);
    $display("ctrl01: dout=%b disp=%0d", dout0, disp0);
    n_checks++; if (dout0 !== 10'b0010101011) $display("FAIL ctrl01_sym got %b exp 0010101011", dout0); else n_pass++;
    n_checks++; if (disp0 !== 5'sd0) $display("FAIL ctrl01_disp got %0d exp 0", disp0); else n_pass++;
  endtask

  task automatic test_guard();
    do_reset();
    step(1'b0, 1'b1, 3'd2, 8'h00, 2'b00, 4'h0);
    step(1'b0, 1'b1, 3'd4, 8'h00, 2'b10, 4'h0);
    $display("vguard: ch0=%b ch1=%b ch2=%b", dout0, dout1, dout2);
    n_checks++; if (dout1 !== 10'b0100110011) $display("FAIL vguard_ch1 got %b exp 0100110011", dout1); else n_pass++;
    n_checks++; if (dout0 !== 10'b1011001100) $display("FAIL vguard_ch0 got %b exp 1011001100", dout0); else n_pass++;
    n_checks++; if (dout2 !== 10'b1011001100) $display("FAIL vguard_ch2 got %b exp 1011001100", dout2); else n_pass++;
    step(1'b0, 1'b1, 3'd0, 8'h00, 2'b11, 4'h0);
    $display("dguard: ch0=%b ch1=%b ch2=%b", dout0, dout1, dout2);
    n_checks++; if (dout1 !== 10'b0100110011) $display("FAIL dguard_ch1 got %b exp 0100110011", dout1); else n_pass++;
    n_checks++; if (dout2 !== 10'b0100110011) $display("FAIL dguard_ch2 got %b exp 0100110011", dout2); else n_pass++;
    n_checks++; if (dout0 !== 10'b0101100011) $display("FAIL dguard_ch0 got %b exp 0101100011", dout0); else n_pass++;
    step(1'b0, 1'b1, 3'd5, 8'h00, 2'b10, 4'h0);
    $display("ctrl11: ch0=%b", dout0);
    n_checks++; if (dout0 !== 10'b1010101011) $display("FAIL ctrl11_sym got %b exp 1010101011", dout0); else n_pass++;
    step(1'b0, 1'b1, 3'd0, 8'h00, 2'b00, 4'h0);
    $display("reserved5: ch0=%b", dout0);
    n_checks++; if (dout0 !== 10'b0101010100) $display("FAIL reserved_sym got %b exp 0101010100", dout0); else n_pass++;
  endtask

  task automatic test_terc4_sweep();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 3'd3, 8'h00, 2'b00, (i < 16) ? i[3:0] : 4'h0);
      if (i >= 1) begin
        $display("terc4 %h: ch0=%b ch1=%b disp=%0d", i - 1, dout0, dout1, disp0);
        n_checks++; if (dout0 !== terc4_tab[i-1]) $display("FAIL terc4_ch0[%0d] got %b exp %b", i - 1, dout0, terc4_tab[i-1]); else n_pass++;
        n_checks++; if (dout1 !== terc4_tab[i-1]) $display("FAIL terc4_ch1[%0d] got %b exp %b", i - 1, dout1, terc4_tab[i-1]); else n_pass++;
        n_checks++; if (disp0 !== 5'sd0) $display("FAIL terc4_disp[%0d] got %0d exp 0", i - 1, disp0); else n_pass++;
      end
    end
  endtask

  task automatic test_ce_stall();
    logic [7:0] px [8];
    logic [9:0] seq_a [8];
    logic [9:0] seq_b [8];
    logic [9:0] held;
    logic signed [4:0] held_disp;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    for (int i = 0; i < 8; i++) px[i] = 8'($urandom_range(0, 255));
    do_reset();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      held = dout0;
      held_disp = disp0;
      step(1'b0, pat[i % 4], 3'd1, px[k], 2'b00, 4'h0);
      if (pat[i % 4]) begin
        seq_a[k] = dout0;
        k++;
        n_checks++; if (dout0 !== cur.sym) $display("FAIL stall_dout[%0d] got %b exp %b", i, dout0, cur.sym); else n_pass++;
        n_checks++; if (int'(disp0) !== cur.disp) $display("FAIL stall_disp[%0d] got %0d exp %0d", i, disp0, cur.disp); else n_pass++;
      end else begin
        n_checks++; if (dout0 !== held) $display("FAIL stall_hold_dout[%0d] got %b exp %b", i, dout0, held); else n_pass++;
        n_checks++; if (disp0 !== held_disp) $display("FAIL stall_hold_disp[%0d] got %0d exp %0d", i, disp0, held_disp); else n_pass++;
      end
      $display("stall cyc %0d ce=%b dout=%b disp=%0d", i, pat[i % 4], dout0, disp0);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'd1, px[i], 2'b00, 4'h0);
      seq_b[i] = dout0;
      n_checks++; if (seq_a[i] !== seq_b[i]) $display("FAIL stall_vs_free[%0d] got %b exp %b", i, seq_a[i], seq_b[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int pixels = 0;
    int seg = 0;
    int len;
    int kind;
    logic [2:0] m;
    logic [1:0] cc;
    bit did_reset = 1'b0;
    do_reset();
    while (pixels < 10000) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: begin m = 3'd1; len = $urandom_range(20, 200); end
        3:       begin m = 3'($urandom_range(0, 7)); if (m == 3'd1) m = 3'd0; len = $urandom_range(1, 12); end
        4:       begin m = 3'd2; len = 2; end
        default: begin m = 3'd3; len = $urandom_range(4, 32); end
      endcase
      seg++;
      $display("random seg %0d mode %0d len %0d", seg, m, len);
      for (int j = 0; j < len + ((m == 3'd3) ? 4 : 0); j++) begin
        logic [2:0] mj;
        mj = m;
        if (m == 3'd3 && (j < 2 || j >= len + 2)) mj = 3'd4;
        cc = 2'($urandom_range(0, 3));
        if (!did_reset && pixels >= 5000) begin
          did_reset = 1'b1;
          step(1'b1, 1'($urandom_range(0, 1)), mj, 8'($urandom_range(0, 255)), cc, 4'h0);
          $display("random mid-stream reset: dout=%b disp=%0d", dout0, disp0);
          n_checks++; if (dout0 !== TOK00) $display("FAIL midrst_dout got %b exp %b", dout0, TOK00); else n_pass++;
          n_checks++; if (disp0 !== 5'sd0) $display("FAIL midrst_disp got %0d exp 0", disp0); else n_pass++;
          n_checks++; if (v0 !== 1'b0) $display("FAIL midrst_valid got %b exp 0", v0); else n_pass++;
        end
        step(1'b0, ($urandom_range(0, 15) != 0), mj, 8'($urandom_range(0, 255)), cc,
             4'($urandom_range(0, 15)));
        if (ce && mj == 3'd1) pixels++;
        n_checks++; if (dout0 !== cur.sym) $display("FAIL rnd_dout t=%0t got %b exp %b", $time, dout0, cur.sym); else n_pass++;
        n_checks++; if (int'(disp0) !== cur.disp) $display("FAIL rnd_disp t=%0t got %0d exp %0d", $time, disp0, cur.disp); else n_pass++;
        n_checks++; if (v0 !== cur_valid) $display("FAIL rnd_valid t=%0t got %b exp %b", $time, v0, cur_valid); else n_pass++;
        n_checks++; if (int'(disp0) > 10 || int'(disp0) < -10) $display("FAIL rnd_bound t=%0t got %0d exp |d|<=10", $time, disp0); else n_pass++;
        if (cur_valid && cur.is_video) begin
          n_checks++; if (decode(dout0) !== cur.d) $display("FAIL rnd_decode t=%0t got %h exp %h", $time, decode(dout0), cur.d); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    terc4_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    ctrl_tab = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    model_cnt = 0;
    cur = '{TOK00, 0, 1'b0, 8'h00};
    cur_valid = 1'b0;
    test_reset();
    test_video_zero();
    test_video_ff_ctrl();
    test_guard();
    test_terc4_sweep();
    test_ce_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
